// File: rtl/label_ram_mp.sv
// Multi-port label RAM: P write ports, P registered read ports with write-first bypass,
// highest-index write wins on address collisions, and a zero-fill sweep after reset.
module label_ram_mp #(
    parameter int S         = 20,
    parameter int K         = 128,
    parameter int P         = 2,
    parameter int INIT_ZERO = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [P-1:0]   wr_en,
    input  logic [P*S-1:0] wr_addr,
    input  logic [P*K-1:0] wr_data,
    input  logic [P-1:0]   rd_en,
    input  logic [P*S-1:0] rd_addr,
    output logic [P*K-1:0] rd_data,
    output logic [P-1:0]   rd_valid,
    output logic           ready,
    output logic           collision
);

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t         r_state;
    logic [S-1:0]   r_cnt;
    logic [P*K-1:0] r_rd_data;
    logic [P-1:0]   r_rd_valid;
    logic           r_ready;
    logic           r_collision;
    logic [K-1:0]   r_mem [0:(2**S)-1];

    logic           w_clr_active;
    logic           w_run;
    logic           w_last;
    logic           w_coll;
    logic [K-1:0]   w_rd_word [P];

    // The release edge out of RST already writes address 0, so the sweep takes 2**S edges.
    assign w_clr_active = rst_n && (INIT_ZERO != 0) &&
                          ((r_state == ST_RST) || (r_state == ST_CLEAR));
    assign w_run        = rst_n && (r_state == ST_RUN);
    assign w_last       = (r_cnt == {S{1'b1}});

    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign ready     = r_ready;
    assign collision = r_collision;

    // Detect two or more enabled write ports targeting the same address.
    always_comb begin
        w_coll = 1'b0;
        for (int i = 0; i < P; i++) begin
            for (int j = i + 1; j < P; j++) begin
                w_coll = w_coll | (wr_en[i] & wr_en[j] &
                                   (wr_addr[i*S +: S] == wr_addr[j*S +: S]));
            end
        end
    end

    // Read word per port: array contents overridden by the highest-index matching write.
    always_comb begin
        for (int i = 0; i < P; i++) begin
            w_rd_word[i] = r_mem[rd_addr[i*S +: S]];
            for (int j = 0; j < P; j++) begin
                w_rd_word[i] = (wr_en[j] && (wr_addr[j*S +: S] == rd_addr[i*S +: S])) ?
                               wr_data[j*K +: K] : w_rd_word[i];
            end
        end
    end

    // Array storage: sweep writes during clear, port writes in RUN with later ports winning.
    always_ff @(posedge clk) begin
        if (w_clr_active) begin
            r_mem[r_cnt] <= {K{1'b0}};
        end else if (w_run) begin
            for (int i = 0; i < P; i++) begin
                if (wr_en[i]) begin
                    r_mem[wr_addr[i*S +: S]] <= wr_data[i*K +: K];
                end
            end
        end
    end

    // Control state machine with registered read, ready and collision outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_RST;
            r_cnt       <= {S{1'b0}};
            r_rd_data   <= {(P*K){1'b0}};
            r_rd_valid  <= {P{1'b0}};
            r_ready     <= 1'b0;
            r_collision <= 1'b0;
        end else begin
            case (r_state)
                ST_RST, ST_CLEAR: begin
                    r_rd_valid  <= {P{1'b0}};
                    r_collision <= 1'b0;
                    if (INIT_ZERO != 0) begin
                        r_cnt <= r_cnt + S'(1'b1);
                        if (w_last) begin
                            r_state <= ST_RUN;
                            r_ready <= 1'b1;
                        end else begin
                            r_state <= ST_CLEAR;
                            r_ready <= 1'b0;
                        end
                    end else begin
                        r_state <= ST_RUN;
                        r_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_ready     <= 1'b1;
                    r_rd_valid  <= rd_en;
                    r_collision <= w_coll;
                    for (int i = 0; i < P; i++) begin
                        if (rd_en[i]) begin
                            r_rd_data[i*K +: K] <= w_rd_word[i];
                        end
                    end
                end
                default: begin
                    r_state     <= ST_RST;
                    r_cnt       <= {S{1'b0}};
                    r_rd_valid  <= {P{1'b0}};
                    r_ready     <= 1'b0;
                    r_collision <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_label_ram_mp.sv
// Self-checking bench for label_ram_mp (S=4, K=8, P=2) against an array-based reference model.
module tb_label_ram_mp;

    localparam int S = 4;
    localparam int K = 8;
    localparam int P = 2;

    logic           clk;
    logic           rst_n;
    logic [P-1:0]   wr_en;
    logic [P*S-1:0] wr_addr;
    logic [P*K-1:0] wr_data;
    logic [P-1:0]   rd_en;
    logic [P*S-1:0] rd_addr;
    logic [P*K-1:0] rd_data;
    logic [P-1:0]   rd_valid;
    logic           ready;
    logic           collision;

    label_ram_mp #(.S(S), .K(K), .P(P), .INIT_ZERO(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .ready(ready), .collision(collision)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  mem_m [16];
    logic        model_run;
    logic [15:0] exp_rd_data;
    logic [1:0]  exp_rd_valid;
    logic        exp_coll;

    // One clock: drive request, update the reference model, then sample #1 after the edge.
    task automatic cycle(input logic [1:0] wen, input logic [3:0] wa0, input logic [3:0] wa1,
                         input logic [7:0] wd0, input logic [7:0] wd1,
                         input logic [1:0] ren, input logic [3:0] ra0, input logic [3:0] ra1);
        logic [3:0] wa [2];
        logic [7:0] wd [2];
        logic [3:0] ra [2];
        logic [7:0] v;
        wa[0] = wa0; wa[1] = wa1; wd[0] = wd0; wd[1] = wd1; ra[0] = ra0; ra[1] = ra1;
        wr_en = wen; wr_addr = {wa1, wa0}; wr_data = {wd1, wd0};
        rd_en = ren; rd_addr = {ra1, ra0};
        if (model_run) begin
            for (int p = 0; p < 2; p++) begin
                if (ren[p]) begin
                    v = mem_m[ra[p]];
                    for (int w = 1; w >= 0; w--) begin
                        if (wen[w] && wa[w] == ra[p]) begin
                            v = wd[w];
                            break;
                        end
                    end
                    exp_rd_data[p*8 +: 8] = v;
                end
            end
            exp_rd_valid = ren;
            exp_coll = (wen == 2'b11) && (wa0 == wa1);
            for (int w = 0; w < 2; w++) begin
                if (wen[w]) mem_m[wa[w]] = wd[w];
            end
        end else begin
            exp_rd_valid = 2'b00;
            exp_coll = 1'b0;
        end
        @(posedge clk);
        #1;
        wr_en = 2'b00;
        rd_en = 2'b00;
    endtask

    task automatic idle();
        cycle(2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b00, 4'd0, 4'd0);
    endtask

    task automatic test_reset();
        int edges;
        rst_n = 1'b0;
        model_run = 1'b0;
        exp_rd_data = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            cycle(2'($urandom), 4'($urandom), 4'($urandom), 8'($urandom), 8'($urandom),
                  2'($urandom), 4'($urandom), 4'($urandom));
            n_tests++;
            if ({rd_data, rd_valid, ready, collision} !== 20'h00000) begin
                n_fail++;
                $display("FAIL reset_outputs: got %h expected 00000", {rd_data, rd_valid, ready, collision});
            end
        end
        rst_n = 1'b1;
        edges = 0;
        while (ready !== 1'b1 && edges < 100) begin
            idle();
            edges++;
            n_tests++;
            if (rd_valid !== 2'b00) begin
                n_fail++;
                $display("FAIL clear_rd_valid: got %b expected 00", rd_valid);
            end
        end
        n_tests++;
        if (edges != 16) begin
            n_fail++;
            $display("FAIL ready_latency: got %0d edges expected 16", edges);
        end
        for (int a = 0; a < 16; a++) mem_m[a] = 8'h00;
        model_run = 1'b1;
    endtask

    task automatic test_clear_reads();
        for (int a = 0; a < 16; a++) begin
            cycle(2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b11, 4'(a), 4'(15 - a));
            n_tests++;
            if (rd_data !== 16'h0000 || rd_valid !== 2'b11) begin
                n_fail++;
                $display("FAIL clear_read a=%0d: got %h/%b expected 0000/11", a, rd_data, rd_valid);
            end
        end
    endtask

    task automatic test_basic();
        cycle(2'b11, 4'd3, 4'd7, 8'hA5, 8'h5A, 2'b00, 4'd0, 4'd0);
        cycle(2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b11, 4'd7, 4'd3);
        n_tests++;
        if (rd_data !== 16'hA55A || rd_valid !== 2'b11 || rd_data !== exp_rd_data) begin
            n_fail++;
            $display("FAIL basic_rw: got %h/%b expected a55a/11", rd_data, rd_valid);
        end
    endtask

    task automatic test_bypass();
        cycle(2'b10, 4'd0, 4'd9, 8'h00, 8'h3C, 2'b01, 4'd9, 4'd0);
        n_tests++;
        if (rd_data[7:0] !== 8'h3C || rd_valid !== 2'b01) begin
            n_fail++;
            $display("FAIL bypass: got %h/%b expected 3c/01", rd_data[7:0], rd_valid);
        end
    endtask

    task automatic test_collision();
        cycle(2'b11, 4'd2, 4'd2, 8'h11, 8'h22, 2'b00, 4'd0, 4'd0);
        n_tests++;
        if (collision !== 1'b1) begin
            n_fail++;
            $display("FAIL collision_pulse: got %b expected 1", collision);
        end
        cycle(2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b01, 4'd2, 4'd0);
        n_tests++;
        if (collision !== 1'b0) begin
            n_fail++;
            $display("FAIL collision_clear: got %b expected 0", collision);
        end
        n_tests++;
        if (rd_data[7:0] !== 8'h22) begin
            n_fail++;
            $display("FAIL collision_winner: got %h expected 22", rd_data[7:0]);
        end
    endtask

    task automatic test_hold();
        cycle(2'b01, 4'd4, 4'd0, 8'hA5, 8'h00, 2'b00, 4'd0, 4'd0);
        cycle(2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b01, 4'd4, 4'd0);
        n_tests++;
        if (rd_data[7:0] !== 8'hA5) begin
            n_fail++;
            $display("FAIL hold_setup: got %h expected a5", rd_data[7:0]);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(2'b11, 4'd4, 4'd4, 8'($urandom), 8'($urandom), 2'b00, 4'd4, 4'd4);
            n_tests++;
            if (rd_data[7:0] !== 8'hA5 || rd_valid[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL hold: got %h/%b expected a5/0", rd_data[7:0], rd_valid[0]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            cycle(2'($urandom), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)),
                  8'($urandom), 8'($urandom),
                  2'($urandom), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)));
            n_tests++;
            if (rd_data !== exp_rd_data || rd_valid !== exp_rd_valid ||
                collision !== exp_coll || ready !== 1'b1) begin
                n_fail++;
                $display("FAIL random i=%0d: got %h/%b/%b/%b expected %h/%b/%b/1",
                         i, rd_data, rd_valid, collision, ready, exp_rd_data, exp_rd_valid, exp_coll);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        int edges;
        rst_n = 1'b0;
        model_run = 1'b0;
        idle();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) idle();
        rst_n = 1'b0;
        idle();
        exp_rd_data = 16'h0000;
        n_tests++;
        if ({rd_data, rd_valid, ready, collision} !== 20'h00000) begin
            n_fail++;
            $display("FAIL midclear_reset: got %h expected 00000", {rd_data, rd_valid, ready, collision});
        end
        rst_n = 1'b1;
        edges = 0;
        while (ready !== 1'b1 && edges < 100) begin
            cycle(2'b11, 4'($urandom), 4'($urandom), 8'($urandom), 8'($urandom),
                  2'b11, 4'($urandom), 4'($urandom));
            edges++;
            n_tests++;
            if (rd_valid !== 2'b00) begin
                n_fail++;
                $display("FAIL midclear_rd_valid: got %b expected 00", rd_valid);
            end
        end
        n_tests++;
        if (edges != 16) begin
            n_fail++;
            $display("FAIL midclear_latency: got %0d edges expected 16", edges);
        end
        for (int a = 0; a < 16; a++) mem_m[a] = 8'h00;
        model_run = 1'b1;
        for (int a = 0; a < 8; a++) begin
            cycle(2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b11, 4'(a), 4'(a + 8));
            n_tests++;
            if (rd_data !== exp_rd_data || rd_data !== 16'h0000) begin
                n_fail++;
                $display("FAIL midclear_zero a=%0d: got %h expected 0000", a, rd_data);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        wr_en = 2'b00; wr_addr = '0; wr_data = '0;
        rd_en = 2'b00; rd_addr = '0;
        model_run = 1'b0;
        exp_rd_data = 16'h0000; exp_rd_valid = 2'b00; exp_coll = 1'b0;
        test_reset();
        test_clear_reads();
        test_basic();
        test_bypass();
        test_collision();
        test_hold();
        test_random();
        test_reset_mid_clear();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/label_ram_mp.md
# label_ram_mp

Parametrised multi-port label RAM for the garbled-circuit datapath. It holds K-bit wire labels in a 2**S-entry array, with P independent write ports and P independent read ports. Reads are registered with write-first bypass and write-write collisions are arbitrated. The array is zero-filled by a hardware sweep after reset, so the design does not depend on a zero-fill memory file. It is the successor to the two-port label RAM and sits between the garbling engine and the label output stage.

## Interface

Parameters:
- S, 20 — address width; depth is 2**S.
- K, 128 — label/data width.
- P, 2 — number of write ports and number of read ports (P ≥ 1).
- INIT_ZERO, 1 — 1: zero-fill sweep after reset; 0: no sweep, contents undefined after power-up.

Ports:
- clk  input  1  — single clock; all logic on rising edge.
- rst_n  input  1  — reset, synchronous, active-low.
- wr_en  input  P  — bit i enables write port i.
- wr_addr  input  P*S  — port i address at bits [i*S +: S].
- wr_data  input  P*K  — port i data at bits [i*K +: K].
- rd_en  input  P  — bit i enables read port i.
- rd_addr  input  P*S  — port i read address at bits [i*S +: S].
- rd_data  output  P*K  — port i registered read data at bits [i*K +: K].
- rd_valid  output  P  — bit i high for one cycle when rd_data port i is updated.
- ready  output  1  — array initialised; ports accepted.
- collision  output  1  — one-cycle pulse: two or more enabled write ports hit the same address in the previous cycle.

## Operation

- The state machine has three states: RST, CLEAR and RUN.
- RST:
  - Entered on any edge with rst_n=0, including mid-CLEAR and mid-RUN.
  - Clears the clear counter to 0.
  - Clears rd_data, rd_valid, ready and collision to 0.
  - Array contents are not touched in this state.
- RST → CLEAR on the first edge with rst_n=1 when INIT_ZERO=1.
- RST → RUN on the first edge with rst_n=1 when INIT_ZERO=0.
- CLEAR:
  - Each edge writes mem[cnt] ← 0 and increments cnt.
  - On the edge that writes address 2**S−1, the state moves to RUN and ready ← 1.
  - All wr_en and rd_en inputs are ignored; rd_valid stays 0.
- RUN, writes:
  - Each enabled port i writes mem[wr_addr_i] ← wr_data_i at the edge.
  - If several enabled ports share an address, the highest-index port wins. The losing writes are dropped and collision pulses the next cycle.
- RUN, reads:
  - Each enabled read port i captures data into rd_data_i at the edge and sets rd_valid_i for one cycle.
  - If any enabled write port targets rd_addr_i in the same cycle, the captured data is that write's data (highest index wins). This is write-first bypass.
  - Otherwise the captured data is mem[rd_addr_i].
- RUN, idle read ports: when rd_en_i=0, rd_data_i holds its last value and rd_valid_i=0.
- Read ports are fully independent. Any number of ports may read the same address in the same cycle.
- ready stays 1 until the next reset.

## Timing

- Read latency is 1 cycle: address presented at edge t, data and rd_valid at t+1.
- Write latency is 1 cycle: a read issued in the cycle after a write returns the new data. A read issued in the same cycle also returns the new data, through the bypass.
- Clear duration with INIT_ZERO=1: ready rises at edge 2**S after the first rst_n=1 edge. For example, with S=4 the first rst_n=1 edge is edge 1 and ready is seen high after edge 16.
- With INIT_ZERO=0, ready rises on the first rst_n=1 edge.
- Reset asserted mid-CLEAR restarts the sweep from address 0 after release.
- collision asserts at edge t+1 for a conflict at edge t and is cleared at t+2 unless the conflict repeats.
- Upstream must not present requests while ready=0; any such requests are discarded with no side effects.

## Test plan

- Reset and clear: S=4, K=8, P=2, INIT_ZERO=1.
  - Stimulus: hold rst_n=0 for 3 cycles, then release; read all 16 addresses after ready.
  - Response: all outputs 0 during reset; ready high exactly 16 edges after release; all reads return 0x00.
- Basic write/read:
  - Stimulus: port 0 writes 0xA5 to addr 3; port 1 writes 0x5A to addr 7; next cycle, port 0 reads 7 and port 1 reads 3.
  - Response: one cycle later rd_data = {0xA5, 0x5A} with rd_valid = 2'b11.
- Write-first bypass:
  - Stimulus: port 1 writes 0x3C to addr 9 while port 0 reads addr 9 in the same cycle.
  - Response: the next cycle rd_data_0 = 0x3C.
- Collision:
  - Stimulus: both ports write addr 2 (port 0 = 0x11, port 1 = 0x22); then read addr 2.
  - Response: collision pulses 1 cycle; the read returns 0x22.
- Reset mid-clear:
  - Stimulus: assert rst_n=0 at clear cnt=5, release, and count edges.
  - Response: ready after exactly 16 edges post-release; no rd_valid during clear, even with rd_en=2'b11 driven.
- Hold behaviour:
  - Stimulus: after a read of 0xA5 on port 0, drive rd_en_0=0 for 4 cycles while writing other data to that address.
  - Response: rd_data_0 stays 0xA5 and rd_valid_0 stays 0.
